// File: rtl/phy_rx_s2p.sv
// ============================================================================
// phy_rx_s2p
// ----------------------------------------------------------------------------
// Receive end of one PHY serial lane. A 1-bit stream sampled on clk_8f
// (MSB first) is deserialised into bytes. The receiver hunts bit-by-bit for
// the COMMA idle symbol. It then checks that COMMA_CNT consecutive commas
// land on byte boundaries and declares the link active. Once active, every
// non-comma byte is presented on data_out with valid_out=1. A comma byte
// clears valid_out and leaves data_out unchanged. Only reset leaves ACTIVE.
//
// Parameters
//   COMMA      idle/alignment symbol (default 8'hBC)
//   COMMA_CNT  aligned commas required to go active, legal range 1..15
//
// Ports
//   clk_8f     in   1   serial bit clock, posedge
//   reset_L    in   1   asynchronous active-low reset
//   enable     in   1   1 = shift/count, 0 = freeze all state (byte_stb low)
//   data_in    in   1   serial data, MSB first
//   data_out   out  8   last received data byte
//   valid_out  out  1   data_out holds a non-comma byte received in ACTIVE
//   byte_stb   out  1   one-cycle pulse per aligned byte boundary
//   comma_cnt  out 16   (PHY_RX_COMMA_STATS_EN only) saturating count of
//                       comma bytes seen at ACTIVE boundaries
//   active     out  1   high while in ACTIVE
//
// Optional feature macro: PHY_RX_COMMA_STATS_EN
// ============================================================================
module phy_rx_s2p #(
    parameter logic [7:0]  COMMA     = 8'hBC,
    parameter int unsigned COMMA_CNT = 4
) (
    input  logic        clk_8f,
    input  logic        reset_L,
    input  logic        enable,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        byte_stb,
`ifdef PHY_RX_COMMA_STATS_EN
    output logic [15:0] comma_cnt,
`endif
    output logic        active
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [3:0] LP_NEED = 4'(COMMA_CNT);

    logic [7:0] r_sreg;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_ccnt;
    logic [1:0] r_state;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_stb;
    logic       r_active;

    logic [7:0] w_nxt;
    logic       w_is_comma;
    logic       w_boundary;
    logic [3:0] w_ccnt_inc;

    // The byte is judged on the edge that samples its last bit, so the
    // decision uses the shift value being loaded, not the stored one.
    assign w_nxt      = {r_sreg[6:0], data_in};
    assign w_is_comma = (w_nxt == COMMA);
    assign w_boundary = (r_state != ST_HUNT) && (r_bit_cnt == 3'd7);
    assign w_ccnt_inc = r_ccnt + 4'd1;

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
            r_ccnt    <= '0;
            r_state   <= ST_HUNT;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_stb     <= 1'b0;
            r_active  <= 1'b0;
        end else if (!enable) begin
            r_stb <= 1'b0;
        end else begin
            r_sreg <= w_nxt;
            r_stb  <= w_boundary;
            case (r_state)
                ST_HUNT: begin
                    if (w_is_comma) begin
                        r_bit_cnt <= '0;
                        r_ccnt    <= 4'd1;
                        if (LP_NEED == 4'd1) begin
                            r_state  <= ST_ACTIVE;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= ST_SYNC;
                        end
                    end
                end
                ST_SYNC: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        if (w_is_comma) begin
                            r_ccnt <= w_ccnt_inc;
                            if (w_ccnt_inc == LP_NEED) begin
                                r_state  <= ST_ACTIVE;
                                r_active <= 1'b1;
                            end
                        end else begin
                            // Misaligned or corrupted: drop back and start
                            // searching from the next edge.
                            r_state <= ST_HUNT;
                            r_ccnt  <= '0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        if (w_is_comma) begin
                            r_valid <= 1'b0;
                        end else begin
                            r_data  <= w_nxt;
                            r_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_HUNT;
                    r_ccnt  <= '0;
                end
            endcase
        end
    end

`ifdef PHY_RX_COMMA_STATS_EN
    logic [15:0] r_comma_cnt;

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            r_comma_cnt <= '0;
        end else if (enable && w_boundary && (r_state == ST_ACTIVE) &&
                     w_is_comma && (r_comma_cnt != '1)) begin
            r_comma_cnt <= r_comma_cnt + 16'd1;
        end
    end

    assign comma_cnt = r_comma_cnt;
`endif

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign byte_stb  = r_stb;
    assign active    = r_active;

endmodule

// File: tb/tb_phy_rx_s2p.sv
module tb_phy_rx_s2p;

    localparam int CCNT = 4;

    logic       clk_8f = 1'b0;
    logic       reset_L;
    logic       enable;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_stb;
    logic       active;
`ifdef PHY_RX_COMMA_STATS_EN
    logic [15:0] comma_cnt;
`endif

    always #5 clk_8f = ~clk_8f;

    phy_rx_s2p #(.COMMA(8'hBC), .COMMA_CNT(CCNT)) dut (
        .clk_8f   (clk_8f),
        .reset_L  (reset_L),
        .enable   (enable),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .byte_stb (byte_stb),
`ifdef PHY_RX_COMMA_STATS_EN
        .comma_cnt(comma_cnt),
`endif
        .active   (active)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the last eight bits, whether we are locked to
    // a byte grid, how many bits have passed since the grid was set, how many
    // aligned commas were seen, and whether the link has come up.
    int         m_win;
    bit         m_locked;
    int         m_pos;
    int         m_commas;
    bit         m_up;
    logic [7:0] m_data;
    bit         m_valid;
    bit         m_stb;
    int         m_stats;

    task automatic model_reset();
        m_win = 0; m_locked = 0; m_pos = 0; m_commas = 0; m_up = 0;
        m_data = 8'h00; m_valid = 0; m_stb = 0; m_stats = 0;
    endtask

    task automatic model_edge(input bit en, input bit din);
        m_stb = 0;
        if (!en) return;
        m_win = ((m_win << 1) | int'(din)) & 255;
        if (!m_locked) begin
            if (m_win == 'hBC) begin
                m_locked = 1; m_pos = 0; m_commas = 1;
                if (CCNT == 1) m_up = 1;
            end
        end else begin
            m_pos++;
            if (m_pos == 8) begin
                m_pos = 0;
                m_stb = 1;
                if (m_up) begin
                    if (m_win == 'hBC) begin
                        m_valid = 0;
                        if (m_stats < 65535) m_stats++;
                    end else begin
                        m_data  = 8'(m_win);
                        m_valid = 1;
                    end
                end else if (m_win == 'hBC) begin
                    m_commas++;
                    if (m_commas == CCNT) m_up = 1;
                end else begin
                    m_locked = 0; m_commas = 0;
                end
            end
        end
    endtask

    task automatic tick(input bit en, input bit din);
        enable  = en;
        data_in = din;
        @(posedge clk_8f);
        #1;
        if (!reset_L) model_reset();
        else model_edge(en, din);
        chk("m_data_out", data_out, m_data);
        chk("m_valid_out", valid_out, m_valid);
        chk("m_byte_stb", byte_stb, m_stb);
        chk("m_active", active, m_up);
`ifdef PHY_RX_COMMA_STATS_EN
        chk("m_comma_cnt", comma_cnt, m_stats);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) tick(1'b1, b[k]);
    endtask

    task automatic send_byte_gappy(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            if ($urandom_range(0, 9) == 0) tick(1'b0, 1'($urandom_range(0, 1)));
            tick(1'b1, b[k]);
        end
    endtask

    // Asynchronous reset applied away from the clock edge; outputs must
    // clear before any further edge.
    task automatic do_reset(input string nm);
        reset_L = 1'b0;
        #1;
        model_reset();
        chk({nm, "_data"}, data_out, 8'h00);
        chk({nm, "_valid"}, valid_out, 1'b0);
        chk({nm, "_stb"}, byte_stb, 1'b0);
        chk({nm, "_active"}, active, 1'b0);
        tick(1'b1, 1'($urandom_range(0, 1)));
        tick(1'b1, 1'($urandom_range(0, 1)));
        reset_L = 1'b1;
    endtask

    task automatic sync_up();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        for (int j = 0; j < CCNT; j++) send_byte(8'hBC);
    endtask

    typedef struct {
        logic [7:0] b;
        logic [7:0] prev_d;
        logic       prev_v;
        logic [7:0] exp_d;
        logic       exp_v;
    } vec_t;

    vec_t vt[4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{b: 8'hDD, prev_d: 8'h00, prev_v: 1'b0, exp_d: 8'hDD, exp_v: 1'b1};
        vt[1] = '{b: 8'hEC, prev_d: 8'hDD, prev_v: 1'b1, exp_d: 8'hEC, exp_v: 1'b1};
        vt[2] = '{b: 8'hBC, prev_d: 8'hEC, prev_v: 1'b1, exp_d: 8'hEC, exp_v: 1'b0};
        vt[3] = '{b: 8'h99, prev_d: 8'hEC, prev_v: 1'b0, exp_d: 8'h99, exp_v: 1'b1};

        reset_L = 1'b0;
        enable  = 1'b1;
        data_in = 1'b0;
        model_reset();

        // Held reset with random data
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)));
            chk("rst_active", active, 1'b0);
            chk("rst_data", data_out, 8'h00);
        end
        reset_L = 1'b1;

        // Sync: 3 zero bits then four commas
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        for (int j = 0; j < CCNT; j++) begin
            send_byte(8'hBC);
            chk("sync_stb", byte_stb, (j > 0));
            chk("sync_active", active, (j == CCNT - 1));
            chk("sync_valid", valid_out, 1'b0);
        end

        // Data table: check value held before the 8th bit, updated after
        for (int i = 0; i < 4; i++) begin
            for (int k = 7; k >= 1; k--) tick(1'b1, vt[i].b[k]);
            chk("tbl_prev_data", data_out, vt[i].prev_d);
            chk("tbl_prev_valid", valid_out, vt[i].prev_v);
            chk("tbl_prev_stb", byte_stb, 1'b0);
            tick(1'b1, vt[i].b[0]);
            chk("tbl_data", data_out, vt[i].exp_d);
            chk("tbl_valid", valid_out, vt[i].exp_v);
            chk("tbl_stb", byte_stb, 1'b1);
            chk("tbl_active", active, 1'b1);
        end

        // Enable gap mid-byte
        begin
            logic [7:0] b;
            b = 8'hA5;
            for (int k = 7; k >= 4; k--) tick(1'b1, b[k]);
            for (int i = 0; i < 5; i++) begin
                tick(1'b0, 1'($urandom_range(0, 1)));
                chk("gap_stb", byte_stb, 1'b0);
                chk("gap_data", data_out, 8'h99);
            end
            for (int k = 3; k >= 0; k--) tick(1'b1, b[k]);
            chk("gap_data_after", data_out, 8'hA5);
            chk("gap_valid_after", valid_out, 1'b1);
        end

        // Reset mid-byte in ACTIVE, then re-sync
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b1);
        do_reset("midrst");
        for (int j = 0; j < CCNT; j++) begin
            send_byte(8'hBC);
            chk("resync_active", active, (j == CCNT - 1));
        end

        // Broken sync: BC BC 55 then four commas
        do_reset("brk_rst");
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h55);
        chk("brk_55_active", active, 1'b0);
        chk("brk_55_stb", byte_stb, 1'b1);
        for (int j = 0; j < CCNT; j++) begin
            send_byte(8'hBC);
            chk("brk_active", active, (j == CCNT - 1));
        end

`ifdef PHY_RX_COMMA_STATS_EN
        do_reset("st_rst");
        sync_up();
        for (int j = 0; j < 3; j++) send_byte(8'hBC);
        chk("stats_three", comma_cnt, 16'd3);
        #2;
        force dut.r_comma_cnt = 16'hFFFF;
        #1;
        release dut.r_comma_cnt;
        m_stats = 65535;
        send_byte(8'hBC);
        chk("stats_sat", comma_cnt, 16'hFFFF);
`endif

        // Randomised traffic against the model
        for (int rep = 0; rep < 4; rep++) begin
            do_reset("rnd_rst");
            for (int i = 0; i < int'($urandom_range(0, 7)); i++)
                tick(1'b1, 1'($urandom_range(0, 1)));
            if (rep != 3) sync_up();
            for (int n = 0; n < 150; n++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 9) < 3) ? 8'hBC : 8'($urandom);
                if ($urandom_range(0, 19) == 0) begin
                    for (int s = 0; s < int'($urandom_range(1, 7)); s++)
                        tick(1'b1, 1'($urandom_range(0, 1)));
                end
                send_byte_gappy(b);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
